// File: rtl/demux8x64_buf.sv
// Registered 1-to-8 distributor: one producer word per cycle, scattered into
// eight one-entry slot buffers, each drained by its own valid/ready consumer.
module demux8x64_buf #(
  parameter int unsigned W  = 64,
  parameter int unsigned CW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [W-1:0]  i,
  input  logic [2:0]    s,
  input  logic          bcast,
  input  logic          in_valid,
  output logic          in_ready,
  output logic [W-1:0]  O0,
  output logic [W-1:0]  O1,
  output logic [W-1:0]  O2,
  output logic [W-1:0]  O3,
  output logic [W-1:0]  O4,
  output logic [W-1:0]  O5,
  output logic [W-1:0]  O6,
  output logic [W-1:0]  O7,
  output logic [7:0]    o_valid,
  input  logic [7:0]    o_ready,
  output logic [CW-1:0] count
);

  logic [W-1:0] slot [8];
  logic [7:0]   free;
  logic [7:0]   drain;
  logic [7:0]   load;
  logic [7:0]   valid_nxt;
  logic         accept;

  // A slot being drained this cycle counts as free, so drain+reload sustains 1 word/cycle.
  always_comb begin
    free      = ~o_valid | o_ready;
    in_ready  = bcast ? (&free) : free[s];
    accept    = in_valid & in_ready;
    load      = '0;
    if (accept) begin
      load = bcast ? 8'hFF : (8'b1 << s);
    end
    drain     = o_valid & o_ready;
    valid_nxt = (o_valid & ~drain) | load;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_valid <= '0;
      count   <= '0;
    end else begin
      o_valid <= valid_nxt;
      if (accept) begin
        count <= count + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned k = 0; k < 8; k++) begin
        slot[k] <= '0;
      end
    end else begin
      for (int unsigned k = 0; k < 8; k++) begin
        if (load[k]) begin
          slot[k] <= i;
        end
      end
    end
  end

  assign O0 = slot[0];
  assign O1 = slot[1];
  assign O2 = slot[2];
  assign O3 = slot[3];
  assign O4 = slot[4];
  assign O5 = slot[5];
  assign O6 = slot[6];
  assign O7 = slot[7];

endmodule
